// File: rtl/seven_bit_add_ctrl_if.sv
// Operand/result bundle for seven_bit_add_ctrl: switch and button inputs plus sum outputs.
interface seven_bit_add_ctrl_if;
    logic [3:0] x;
    logic       pb;
    logic       clr;
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] z;
    logic       carry;
    logic [2:0] state;
    logic       done;

    modport master (output x, pb, clr, input a, b, z, carry, state, done);
    modport slave  (input x, pb, clr, output a, b, z, carry, state, done);
endinterface

// File: rtl/seven_bit_add_ctrl.sv
// Nibble-serial 7-bit operand loader and adder driven by a single pushbutton.
// Optional macro PB_SYNC_EN adds a 2-flop synchronizer and debounce counter on pb.
module seven_bit_add_ctrl
`ifdef PB_SYNC_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic                 clk,
    input  logic                 rst,
    seven_bit_add_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        LOAD_AL = 3'd0,
        LOAD_AH = 3'd1,
        LOAD_BL = 3'd2,
        LOAD_BH = 3'd3,
        ADD     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t     state_q;
    logic [6:0] a_q;
    logic [6:0] b_q;
    logic [6:0] z_q;
    logic       carry_q;
    logic       done_q;
    logic [7:0] sum_d;
    logic       acc;

`ifdef PB_SYNC_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          fired_q;
    logic [CW-1:0] cnt_q;

    // fired_q blocks re-triggering until pb releases; clr also consumes a press in progress
    always_comb begin
        acc = sync2_q && (cnt_q == CW'(DEBOUNCE_CYCLES)) && !fired_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            fired_q <= 1'b0;
        end else begin
            sync1_q <= bus.pb;
            sync2_q <= sync1_q;
            if (!sync2_q) begin
                cnt_q   <= '0;
                fired_q <= 1'b0;
            end else begin
                if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (acc || bus.clr) begin
                    fired_q <= 1'b1;
                end
            end
        end
    end
`else
    logic pb_q;

    always_comb begin
        acc = bus.pb & ~pb_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pb_q <= 1'b0;
        end else begin
            pb_q <= bus.pb;
        end
    end
`endif

    always_comb begin
        sum_d = {1'b0, a_q} + {1'b0, b_q};
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state_q <= LOAD_AL;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD_AL: if (acc) begin
                    a_q[3:0] <= bus.x;
                    state_q  <= LOAD_AH;
                end
                LOAD_AH: if (acc) begin
                    a_q[6:4] <= bus.x[2:0];
                    state_q  <= LOAD_BL;
                end
                LOAD_BL: if (acc) begin
                    b_q[3:0] <= bus.x;
                    state_q  <= LOAD_BH;
                end
                LOAD_BH: if (acc) begin
                    b_q[6:4] <= bus.x[2:0];
                    state_q  <= ADD;
                end
                ADD: begin
                    {carry_q, z_q} <= sum_d;
                    state_q        <= DONE;
                    done_q         <= 1'b1;
                end
                DONE: if (acc) begin
                    state_q <= LOAD_AL;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= LOAD_AL;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign bus.z     = z_q;
    assign bus.carry = carry_q;
    assign bus.state = state_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_seven_bit_add_ctrl.sv
// Directed self-checking bench for seven_bit_add_ctrl (default and PB_SYNC_EN builds).
module tb_seven_bit_add_ctrl;

    localparam int unsigned DB = 4;
`ifdef PB_SYNC_EN
    localparam int unsigned LAT = DB + 3;
    localparam int unsigned REL = 3;
`else
    localparam int unsigned LAT = 1;
    localparam int unsigned REL = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    seven_bit_add_ctrl_if bus ();

`ifdef PB_SYNC_EN
    seven_bit_add_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    seven_bit_add_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press_hold(input logic [3:0] v);
        bus.x  = v;
        bus.pb = 1'b1;
        repeat (LAT) tick();
    endtask

    task automatic release_pb();
        bus.pb = 1'b0;
        repeat (REL) tick();
    endtask

    task automatic press(input logic [3:0] v);
        press_hold(v);
        release_pb();
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [6:0] ea,
                             input logic [6:0] eb, input logic [6:0] ez, input logic ec);
        check({tag, ".state"}, 8'(bus.state), 8'(st));
        check({tag, ".a"}, 8'(bus.a), 8'(ea));
        check({tag, ".b"}, 8'(bus.b), 8'(eb));
        check({tag, ".z"}, 8'(bus.z), 8'(ez));
        check({tag, ".carry"}, 8'(bus.carry), 8'(ec));
        check({tag, ".done"}, 8'(bus.done), (st == 3'd5) ? 8'd1 : 8'd0);
    endtask

    initial begin
        bus.x   = 4'h0;
        bus.pb  = 1'b0;
        bus.clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_all("reset", 3'd0, 7'h00, 7'h00, 7'h00, 1'b0);

        // nominal add 0x25 + 0x1A
        press(4'h5);
        check("ld_al.a", 8'(bus.a), 8'h05);
        check("ld_al.state", 8'(bus.state), 8'd1);
        press(4'h2);
        check("ld_ah.a", 8'(bus.a), 8'h25);
        press(4'hA);
        check("ld_bl.b", 8'(bus.b), 8'h0A);
        press(4'h1);
        check_all("nominal", 3'd5, 7'h25, 7'h1A, 7'h3F, 1'b0);

        // press in DONE returns to LOAD_AL without capture
        press(4'hC);
        check_all("done_press", 3'd0, 7'h25, 7'h1A, 7'h3F, 1'b0);

        // abort in LOAD_BL
        press(4'h5);
        press(4'h2);
        check("pre_abort.state", 8'(bus.state), 8'd2);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check_all("abort", 3'd0, 7'h00, 7'h00, 7'h00, 1'b0);

        // clr coincident with press: no capture
        bus.clr = 1'b1;
        press_hold(4'h9);
        bus.clr = 1'b0;
        check_all("clr_press", 3'd0, 7'h00, 7'h00, 7'h00, 1'b0);
        release_pb();
        check("clr_press_after.state", 8'(bus.state), 8'd0);

        // overflow 0x7F + 0x01; x[3] ignored in high nibble
        press(4'hF);
        press(4'hF);
        press(4'h1);
        press(4'h8);
        check_all("ovf1", 3'd5, 7'h7F, 7'h01, 7'h00, 1'b1);
        press(4'h0);
        check_all("ovf1_exit", 3'd0, 7'h7F, 7'h01, 7'h00, 1'b1);
        press(4'hF);
        press(4'h7);
        press(4'hF);
        press(4'h7);
        check_all("ovf2", 3'd5, 7'h7F, 7'h7F, 7'h7E, 1'b1);

        // pb held across ADD and DONE: one advance only
        press(4'h0);
        press(4'h1);
        press(4'h0);
        press(4'h2);
        press_hold(4'h0);
        check_all("add_cycle", 3'd4, 7'h01, 7'h02, 7'h7E, 1'b1);
        tick();
        check_all("held_done", 3'd5, 7'h01, 7'h02, 7'h03, 1'b0);
        repeat (10) tick();
        check("held_done_stay.state", 8'(bus.state), 8'd5);
        release_pb();

        // reset during ADD discards the result
        press(4'h0);
        press(4'h3);
        press(4'h0);
        press(4'h4);
        press_hold(4'h0);
        check("rst_add.pre_state", 8'(bus.state), 8'd4);
        rst    = 1'b1;
        bus.pb = 1'b0;
        tick();
        rst = 1'b0;
        check_all("rst_add", 3'd0, 7'h00, 7'h00, 7'h00, 1'b0);
        repeat (REL) tick();

        // pb held 100 cycles in LOAD_AL
        bus.x  = 4'h3;
        bus.pb = 1'b1;
        repeat (100) tick();
        check("hold100.state", 8'(bus.state), 8'd1);
        check("hold100.a", 8'(bus.a), 8'h03);
        release_pb();
        check("hold100_rel.state", 8'(bus.state), 8'd1);

`ifdef PB_SYNC_EN
        // glitch shorter than the debounce window
        bus.x  = 4'h6;
        bus.pb = 1'b1;
        repeat (DB - 1) tick();
        bus.pb = 1'b0;
        repeat (8) tick();
        check("glitch.state", 8'(bus.state), 8'd1);
        check("glitch.a", 8'(bus.a), 8'h03);

        // press-to-capture latency of 2+DB+1 edges
        bus.x  = 4'hA;
        bus.pb = 1'b1;
        repeat (DB + 2) tick();
        check("lat_early.state", 8'(bus.state), 8'd1);
        tick();
        check("lat_edge.state", 8'(bus.state), 8'd2);
        check("lat_edge.a", 8'(bus.a), 8'h23);
        release_pb();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seven_bit_add_ctrl.md
SEVEN_BIT_ADD_CTRL -- requirements
Module: seven_bit_add_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, consecutive synchronized-high cycles before a press is accepted (PB_SYNC_EN builds only).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: x  input  4  operand nibble from switches.
REQ-005 Port: pb  input  1  "load/next" pushbutton.
REQ-006 Port: clr  input  1  synchronous abort; restarts the operand sequence.
REQ-007 Port: a  output  7  operand A register.
REQ-008 Port: b  output  7  operand B register.
REQ-009 Port: z  output  7  registered sum (a+b) mod 128.
REQ-010 Port: carry  output  1  registered carry-out of a+b.
REQ-011 Port: state  output  3  current FSM state encoding.
REQ-012 Port: done  output  1  high while result is valid (DONE state).

Function
REQ-013 FSM states and encodings SHALL be: LOAD_AL=0, LOAD_AH=1, LOAD_BL=2, LOAD_BH=3, ADD=4, DONE=5; encodings 6-7 unreachable and SHALL go to LOAD_AL on the next edge.
REQ-014 An accepted press ("acc", one-cycle internal pulse) SHALL cause the following capture at the next edge:
- LOAD_AL: a[3:0]<=x; ->LOAD_AH
- LOAD_AH: a[6:4]<=x[2:0]; ->LOAD_BL
- LOAD_BL: b[3:0]<=x; ->LOAD_BH
- LOAD_BH: b[6:4]<=x[2:0]; ->ADD
REQ-015 x[3] SHALL be ignored in the high-nibble states.
REQ-016 ADD SHALL last exactly one cycle: {carry,z}<=a+b (8-bit result); ->DONE; acc ignored in ADD.
REQ-017 done SHALL be 1 exactly when state==DONE; z/carry SHALL hold stable in DONE.
REQ-018 acc in DONE SHALL go to LOAD_AL without capturing x; a, b, z and carry SHALL retain their values until overwritten.
REQ-019 clr=1 SHALL, at the next edge in any state: force LOAD_AL; clear a, b, z and carry to 0; discard any in-progress press.
REQ-020 clr and acc in the same cycle: clr SHALL win, and no capture SHALL occur.
REQ-021 At most one acc SHALL be generated per press; holding pb high SHALL NOT advance more than one state.
REQ-022 Without PB_SYNC_EN, acc SHALL equal pb & ~pb_q (pb_q = pb registered once).
- Capture occurs on the edge after pb first samples high.

Reset
REQ-023 rst SHALL have priority over clr and acc.
REQ-024 On rst, the block SHALL set:
- state=LOAD_AL
- a=0, b=0, z=0, carry=0, done=0
- synchronizer, debounce counter and edge flops cleared
REQ-025 rst asserted mid-sequence, including in ADD, SHALL discard partial operands; no result write SHALL occur.

Configuration
REQ-026 Macro PB_SYNC_EN defined: pb SHALL pass through a 2-flop synchronizer feeding a saturating debounce counter.
- Counter resets to 0 whenever the synchronized pb is 0.
- acc pulses for one cycle when the counter reaches DEBOUNCE_CYCLES.
- A new acc requires the synchronized pb to return to 0 first.
- Press-to-capture latency is 2+DEBOUNCE_CYCLES+1 cycles.
REQ-027 Macro PB_SYNC_EN undefined: no synchronizer or counter; edge detection per REQ-022 only.

Verification
REQ-028 Nominal add: load 5, 2, A, 1 (a=0x25, b=0x1A) -> after ADD: z=0x3F, carry=0, done=1, state=5.
REQ-029 Overflow: a=0x7F, b=0x01 -> z=0x00, carry=1; then a=0x7F, b=0x7F -> z=0x7E, carry=1.
REQ-030 Abort: after loading a=0x25, assert clr in LOAD_BL -> next edge: state=0, a=b=z=0, carry=0; a second clr coincident with a pb press -> no capture.
REQ-031 Hold and ignore:
- pb held high 100 cycles in LOAD_AL -> exactly one transition.
- Press during ADD -> ignored.
- Press in DONE -> state=0, a/b/z unchanged.
REQ-032 PB_SYNC_EN build:
- pb glitch high for DEBOUNCE_CYCLES-1 cycles -> no acc.
- Stable press -> capture exactly 2+DEBOUNCE_CYCLES+1 cycles after pb rises.
REQ-033 Reset mid-operation: rst asserted in the ADD cycle -> z=0, carry=0, done=0, state=0 on the next edge.
